led_pattern_gen: RTL and testbench

Multi-channel LED driver generating steady, blinking and one-shot patterns from a shared, parametrised time base. It replaces fixed-rate single-LED blinkers on the board-level status path. A simple register-write port configures each channel's mode and half-period at run time.

---
 rtl/led_pattern_gen.sv | 133 +++++++++++++
 tb/tb_led_pattern_gen.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator (OFF/ON/BLINK/ONESHOT) from a shared prescaled tick.
// Latency: a write shows on led one clock later; tick-driven led/done changes are registered.
// Backpressure: none; every write is accepted. Optional feature macro: LED_ACTIVE_LOW_EN (led = ~state).
module led_pattern_gen #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000,
    parameter int CH_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [CH_W-1:0]        wr_ch,
    input  logic [1:0]             wr_mode,
    input  logic [CNT_W-1:0]       wr_half,
    output logic [(2**CH_W)-1:0]   led,
    output logic [(2**CH_W)-1:0]   done,
    output logic                   tick
);

    localparam int CHANNELS = 2 ** CH_W;
    // DIV must be at least 2 so the prescaler has a distinct terminal count.
    localparam int DIV      = CLK_HZ / TICK_HZ;
    localparam int PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;

    // Prescaler state
    logic [PW-1:0]         pcnt_q;
    logic [PW-1:0]         pcnt_d;

    // Per-channel state
    mode_e                 mode_q  [CHANNELS];
    mode_e                 mode_d  [CHANNELS];
    logic [CNT_W-1:0]      half_q  [CHANNELS];
    logic [CNT_W-1:0]      half_d  [CHANNELS];
    logic [CNT_W-1:0]      cnt_q   [CHANNELS];
    logic [CNT_W-1:0]      cnt_d   [CHANNELS];
    logic [CHANNELS-1:0]   state_q;
    logic [CHANNELS-1:0]   state_d;
    logic [CHANNELS-1:0]   done_q;
    logic [CHANNELS-1:0]   done_d;

    // Tick is a pure decode of the prescaler terminal count; writes never disturb it.
    assign tick = (pcnt_q == PCNT_LAST);

    // Free-running prescaler: 0..DIV-1 then wrap.
    always_comb begin
        pcnt_d = pcnt_q + PW'(1);
        if (pcnt_q == PCNT_LAST) begin
            pcnt_d = '0;
        end
    end

    // Per-channel next state: a write to a channel takes priority over its tick-driven update.
    always_comb begin
        state_d = state_q;
        done_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            mode_d[i] = mode_q[i];
            half_d[i] = half_q[i];
            cnt_d[i]  = cnt_q[i];

            if (wr_en && (wr_ch == CH_W'(i))) begin
                mode_d[i]  = mode_e'(wr_mode);
                // A zero half-period would never expire; clamp it to one tick.
                half_d[i]  = (wr_half == '0) ? CNT_W'(1) : wr_half;
                cnt_d[i]   = '0;
                state_d[i] = (wr_mode != 2'b00);
            end else if (tick && ((mode_q[i] == MODE_BLINK) || (mode_q[i] == MODE_ONESHOT))) begin
                // half is never 0, so cnt stays within 0..half-1 and cannot wrap.
                if (cnt_q[i] == (half_q[i] - CNT_W'(1))) begin
                    cnt_d[i] = '0;
                    if (mode_q[i] == MODE_BLINK) begin
                        state_d[i] = ~state_q[i];
                    end else begin
                        state_d[i] = 1'b0;
                        mode_d[i]  = MODE_OFF;
                        done_d[i]  = 1'b1;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Prescaler register; reset realigns the tick phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    // Channel registers; reset overrides any same-cycle write and aborts patterns silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            done_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i] <= MODE_OFF;
                half_q[i] <= CNT_W'(1);
                cnt_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i] <= mode_d[i];
                half_q[i] <= half_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    assign done = done_q;

`ifdef LED_ACTIVE_LOW_EN
    // Board LEDs sink current: a dark LED (OFF or reset) drives 1.
    assign led = ~state_q;
`else
    assign led = state_q;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen with DIV = 10 (CLK_HZ=100, TICK_HZ=10).
// Expected values are queued when stimulus is applied and popped when the DUT output is observed.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_led_pattern_gen;

    localparam int CH_W  = 2;
    localparam int CNT_W = 16;
    localparam int NCH   = 4;

    localparam logic [1:0] M_OFF     = 2'b00;
    localparam logic [1:0] M_ON      = 2'b01;
    localparam logic [1:0] M_BLINK   = 2'b10;
    localparam logic [1:0] M_ONESHOT = 2'b11;

    localparam int SEL_TICK = 4;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic POL = 1'b1;
`else
    localparam logic POL = 1'b0;
`endif
    localparam logic [NCH-1:0] LED_DARK = {NCH{POL}};

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [1:0]        wr_mode;
    logic [CNT_W-1:0]  wr_half;
    logic [NCH-1:0]    led;
    logic [NCH-1:0]    done;
    logic              tick;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];

    led_pattern_gen #(
        .CLK_HZ  (100),
        .TICK_HZ (10),
        .CH_W    (CH_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_mode (wr_mode),
        .wr_half (wr_half),
        .led     (led),
        .done    (done),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        sb_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
        end else begin
            e.tag = "sb_empty";
            e.exp = 32'hFFFF_FFFF;
        end
        check_val(e.tag, got, e.exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Logical (polarity-corrected) LED bit, or tick when sel == SEL_TICK.
    function automatic logic probe(input int sel);
        logic [1:0] idx;
        idx = sel[1:0];
        if (sel == SEL_TICK) return tick;
        return led[idx] ^ POL;
    endfunction

    // Counts clocks until the probed signal equals val; stops at limit.
    task automatic wait_for(input int sel, input logic val, input int limit, output int n);
        n = 0;
        while ((probe(sel) !== val) && (n < limit)) begin
            step();
            n++;
        end
    endtask

    task automatic wr(input int ch, input logic [1:0] mode, input int half);
        wr_en   = 1'b1;
        wr_ch   = CH_W'(ch);
        wr_mode = mode;
        wr_half = CNT_W'(half);
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        int n;
        int ticks;
        logic [NCH-1:0] acc_led;
        logic [NCH-1:0] acc_done;

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_ch   = '0;
        wr_mode = M_OFF;
        wr_half = '0;

        // Reset held for 3 cycles.
        sb_push("rst_led", 32'(LED_DARK));
        sb_push("rst_done", 0);
        sb_push("rst_tick", 0);
        repeat (3) step();
        sb_pop(32'(led));
        sb_pop(32'(done));
        sb_pop(32'(tick));

        // Current cycle is the first with pcnt = 0 after release.
        rst = 1'b0;
        sb_push("tick_first", 9);
        wait_for(SEL_TICK, 1'b1, 40, n);
        sb_pop(32'(n));
        for (int k = 0; k < 3; k++) begin
            sb_push($sformatf("tick_period%0d", k), 10);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            wait_for(SEL_TICK, 1'b1, 40, n);
            sb_pop(32'(n + 1));
        end

        // ON / OFF on channel 2.
        sb_push("on_led", 32'(LED_DARK ^ 4'b0100));
        wr(2, M_ON, 1);
        sb_pop(32'(led));
        sb_push("off_led", 32'(LED_DARK));
        wr(2, M_OFF, 1);
        sb_pop(32'(led));

        // BLINK on channel 0, half = 3 ticks = 30 clocks.
        sb_push("blink_on", 1);
        sb_push("blink_first_21_30", 1);
        for (int k = 0; k < 8; k++) begin
            sb_push($sformatf("blink_half%0d", k), 30);
        end
        wr(0, M_BLINK, 3);
        sb_pop(32'(probe(0)));
        wait_for(0, 1'b0, 40, n);
        sb_pop(32'((n >= 21) && (n <= 30)));
        for (int k = 0; k < 8; k++) begin
            wait_for(0, (k % 2 == 0) ? 1'b1 : 1'b0, 40, n);
            sb_pop(32'(n));
        end

        // Zero half-period on channel 1 behaves as half = 1.
        sb_push("zh_on", 1);
        sb_push("zh_first_1_10", 1);
        for (int k = 0; k < 4; k++) begin
            sb_push($sformatf("zh_half%0d", k), 10);
        end
        wr(1, M_BLINK, 0);
        sb_pop(32'(probe(1)));
        wait_for(1, 1'b0, 20, n);
        sb_pop(32'((n >= 1) && (n <= 10)));
        for (int k = 0; k < 4; k++) begin
            wait_for(1, (k % 2 == 0) ? 1'b1 : 1'b0, 20, n);
            sb_pop(32'(n));
        end
        wr(1, M_OFF, 1);

        // ONESHOT on channel 3, half = 2.
        sb_push("os_on", 1);
        sb_push("os_fall_11_20", 1);
        sb_push("os_done", 32'h8);
        sb_push("os_done_clear", 0);
        sb_push("os_stays_off", 35);
        wr(3, M_ONESHOT, 2);
        sb_pop(32'(probe(3)));
        wait_for(3, 1'b0, 40, n);
        sb_pop(32'((n >= 11) && (n <= 20)));
        sb_pop(32'(done));
        step();
        sb_pop(32'(done));
        wait_for(3, 1'b1, 35, n);
        sb_pop(32'(n));

        // Re-write in the expiry cycle: write wins, no done, pattern restarts.
        wr(3, M_ONESHOT, 2);
        ticks = 0;
        for (int c = 0; (c < 40) && (ticks < 2); c++) begin
            if (tick) ticks++;
            if (ticks < 2) step();
        end
        sb_push("wx_found_expiry", 2);
        sb_push("wx_led", 1);
        sb_push("wx_done", 0);
        sb_push("wx_restart_fall", 20);
        sb_push("wx_restart_done", 32'h8);
        sb_pop(32'(ticks));
        wr(3, M_ONESHOT, 2);
        sb_pop(32'(probe(3)));
        sb_pop(32'(done));
        wait_for(3, 1'b0, 40, n);
        sb_pop(32'(n));
        sb_pop(32'(done));

        // Reset during channel 0 BLINK, with a competing write to channel 2.
        wait_for(0, 1'b1, 40, n);
        sb_push("mr_led", 32'(LED_DARK));
        sb_push("mr_done", 0);
        sb_push("mr_quiet_led", 0);
        sb_push("mr_quiet_done", 0);
        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_ch   = 2'd2;
        wr_mode = M_ON;
        wr_half = 16'd1;
        step();
        rst   = 1'b0;
        wr_en = 1'b0;
        sb_pop(32'(led));
        sb_pop(32'(done));
        acc_led  = '0;
        acc_done = '0;
        for (int c = 0; c < 40; c++) begin
            acc_led  = acc_led | (led ^ LED_DARK);
            acc_done = acc_done | done;
            step();
        end
        sb_pop(32'(acc_led));
        sb_pop(32'(acc_done));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
